// File: rtl/prom_access_timer_pkg.sv
// Shared types and sizing helpers for the PROM bus-side access timer.
package prom_timing_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, VALID, HOLD} state_t;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 4;

   // Counter width for the largest preload, never narrower than one bit.
   function automatic int cntWidth(input int accessCycles, input int holdCycles);
      int m;
      m = accessCycles;
      if (holdCycles > m) m = holdCycles;
      if (m < 1) m = 1;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/prom_access_timer_bit_sync.sv
// Multi-flop synchronizer with a configurable width, depth and reset value.
module bit_sync #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/prom_access_timer.sv
// Bus-side timing stage for the PROM replacement: synchronizes the pins, delays
// data/oe by an access time and stretches them by a hold time afterwards.
module prom_access_timer
   import prom_timing_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEFAULT,
   parameter int DATA_W        = DATA_W_DEFAULT,
   parameter int SYNC_STAGES   = 2,
   parameter int ACCESS_CYCLES = 4,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_pin,
   input  logic              ce1_n,
   input  logic              ce2_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] data,
   output logic              oe
);

   localparam int            CW          = cntWidth(ACCESS_CYCLES, HOLD_CYCLES);
   localparam logic [CW-1:0] ACCESS_LOAD = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD   = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   logic [ADDR_W-1:0] addrSync;
   logic [1:0]        ceSync;
   logic [ADDR_W-1:0] addrPrev_q;
   logic              sel;
   logic              achg;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [ADDR_W-1:0] romAddr_q;
   logic [DATA_W-1:0] data_q;
   logic              oe_q;

   bit_sync #(.WIDTH(ADDR_W), .DEPTH(SYNC_STAGES), .RESET_VAL('0)) uAddrSync (
      .clk (clk),
      .rst (rst),
      .d_i (addr_pin),
      .q_o (addrSync)
   );

   // Enables reset to the deselected (high) level so a reset never looks like a select.
   bit_sync #(.WIDTH(2), .DEPTH(SYNC_STAGES), .RESET_VAL(2'b11)) uCeSync (
      .clk (clk),
      .rst (rst),
      .d_i ({ce2_n, ce1_n}),
      .q_o (ceSync)
   );

   always_ff @(posedge clk) begin
      if (rst) addrPrev_q <= '0;
      else     addrPrev_q <= addrSync;
   end

   assign sel  = ~ceSync[0] & ~ceSync[1];
   assign achg = (addrSync != addrPrev_q);

   // With no hold time, VALID performs the HOLD exit itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         romAddr_q <= '0;
         data_q    <= '0;
         oe_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               oe_q <= 1'b0;
               if (sel) begin
                  state_q   <= ACCESS;
                  romAddr_q <= addrSync;
                  cnt_q     <= ACCESS_LOAD;
               end
            end
            ACCESS: begin
               if (!sel) begin
                  state_q <= IDLE;
               end else if (achg) begin
                  romAddr_q <= addrSync;
                  cnt_q     <= ACCESS_LOAD;
               end else if (cnt_q == '0) begin
                  state_q <= VALID;
                  data_q  <= rom_data;
                  oe_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            VALID: begin
               if (!sel || achg) begin
                  if (HOLD_CYCLES == 0) begin
                     oe_q <= 1'b0;
                     if (sel) begin
                        state_q   <= ACCESS;
                        romAddr_q <= addrSync;
                        cnt_q     <= ACCESS_LOAD;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     state_q <= HOLD;
                     cnt_q   <= HOLD_LOAD;
                  end
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  oe_q <= 1'b0;
                  if (sel) begin
                     state_q   <= ACCESS;
                     romAddr_q <= addrSync;
                     cnt_q     <= ACCESS_LOAD;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr = romAddr_q;
   assign data     = data_q;
   assign oe       = oe_q;

endmodule

// File: tb/tb_prom_access_timer.sv
// Scoreboard bench: stimulus queues expected oe edges, monitors pop and compare.
module tb_prom_access_timer;

   typedef struct {
      int         cycle;
      logic [3:0] data;
      logic [7:0] addr;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addrPin0, addrPin1, romAddr0, romAddr1;
   logic       ce1n0, ce2n0, ce1n1, ce2n1;
   logic [3:0] romData0, romData1, data0, data1;
   logic       oe0, oe1;
   logic       oePrev0 = 1'b0;
   logic       oePrev1 = 1'b0;
   logic       rstSeen = 1'b1;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         k, j;
   expect_t    riseQ0[$], fallQ0[$], riseQ1[$], fallQ1[$];

   always #5 clk = ~clk;

   function automatic logic [3:0] romModel(input logic [7:0] a);
      case (a)
         8'h3A:   return 4'hC;
         8'h3B:   return 4'h5;
         8'hFF:   return 4'h9;
         8'h00:   return 4'h6;
         8'h10:   return 4'h3;
         8'h20:   return 4'hE;
         default: return 4'h0;
      endcase
   endfunction

   assign romData0 = romModel(romAddr0);
   assign romData1 = romModel(romAddr1);

   prom_access_timer dut0 (
      .clk      (clk),
      .rst      (rst),
      .addr_pin (addrPin0),
      .ce1_n    (ce1n0),
      .ce2_n    (ce2n0),
      .rom_addr (romAddr0),
      .rom_data (romData0),
      .data     (data0),
      .oe       (oe0)
   );

   prom_access_timer #(.ACCESS_CYCLES(1), .HOLD_CYCLES(0)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .addr_pin (addrPin1),
      .ce1_n    (ce1n1),
      .ce2_n    (ce2n1),
      .rom_addr (romAddr1),
      .rom_data (romData1),
      .data     (data1),
      .oe       (oe1)
   );

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rstSeen <= rst;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [7:0] a, input logic c1, input logic c2);
      if (which == 0) begin
         addrPin0 = a; ce1n0 = c1; ce2n0 = c2;
      end else begin
         addrPin1 = a; ce1n1 = c1; ce2n1 = c2;
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Edges of oe across a reset edge are not transactions and are skipped.
   always @(negedge clk) begin
      expect_t e;
      if (!rstSeen) begin
         if (oe0 === 1'b1 && oePrev0 !== 1'b1) begin
            if (riseQ0.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL rise0_unexpected: oe rose at cycle %0d, none expected", cyc);
            end else begin
               e = riseQ0.pop_front();
               checkOutput("rise0_cycle", cyc, e.cycle);
               checkOutput("rise0_data", data0, e.data);
               checkOutput("rise0_romaddr", romAddr0, e.addr);
            end
         end
         if (oe0 === 1'b0 && oePrev0 === 1'b1) begin
            if (fallQ0.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL fall0_unexpected: oe fell at cycle %0d, none expected", cyc);
            end else begin
               e = fallQ0.pop_front();
               checkOutput("fall0_cycle", cyc, e.cycle);
               checkOutput("fall0_data", data0, e.data);
            end
         end
      end
      oePrev0 = oe0;
   end

   always @(negedge clk) begin
      expect_t e;
      if (!rstSeen) begin
         if (oe1 === 1'b1 && oePrev1 !== 1'b1) begin
            if (riseQ1.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL rise1_unexpected: oe rose at cycle %0d, none expected", cyc);
            end else begin
               e = riseQ1.pop_front();
               checkOutput("rise1_cycle", cyc, e.cycle);
               checkOutput("rise1_data", data1, e.data);
               checkOutput("rise1_romaddr", romAddr1, e.addr);
            end
         end
         if (oe1 === 1'b0 && oePrev1 === 1'b1) begin
            if (fallQ1.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL fall1_unexpected: oe fell at cycle %0d, none expected", cyc);
            end else begin
               e = fallQ1.pop_front();
               checkOutput("fall1_cycle", cyc, e.cycle);
               checkOutput("fall1_data", data1, e.data);
            end
         end
      end
      oePrev1 = oe1;
   end

   initial begin
      rst = 1'b1;
      applyStimulus(0, 8'h00, 1'b1, 1'b1);
      applyStimulus(1, 8'h00, 1'b1, 1'b1);
      waitCycles(3);
      checkOutput("reset0_oe", oe0, 0);
      checkOutput("reset0_data", data0, 0);
      checkOutput("reset0_romaddr", romAddr0, 0);
      checkOutput("reset1_oe", oe1, 0);
      checkOutput("reset1_data", data1, 0);
      checkOutput("reset1_romaddr", romAddr1, 0);
      rst = 1'b0;
      waitCycles(2);

      // Basic read: six clocks from first sampling to oe.
      k = cyc + 1;
      applyStimulus(0, 8'h3A, 1'b0, 1'b0);
      riseQ0.push_back('{k + 6, 4'hC, 8'h3A});
      waitCycles(4);
      checkOutput("access_oe_low", oe0, 0);
      checkOutput("access_data_zero", data0, 0);
      checkOutput("access_romaddr", romAddr0, 8'h3A);
      waitCycles(5);

      // Deselect from VALID: oe held through the sync and hold delay.
      j = cyc + 1;
      applyStimulus(0, 8'h3A, 1'b1, 1'b0);
      fallQ0.push_back('{j + 4, 4'hC, 8'h00});
      waitCycles(3);
      checkOutput("hold_oe", oe0, 1);
      checkOutput("hold_data", data0, 4'hC);
      waitCycles(4);

      // Address changes while selected, including the FF to 00 wrap.
      k = cyc + 1;
      applyStimulus(0, 8'h3A, 1'b0, 1'b0);
      riseQ0.push_back('{k + 6, 4'hC, 8'h3A});
      waitCycles(8);
      j = cyc + 1;
      applyStimulus(0, 8'h3B, 1'b0, 1'b0);
      fallQ0.push_back('{j + 4, 4'hC, 8'h00});
      riseQ0.push_back('{j + 8, 4'h5, 8'h3B});
      waitCycles(10);
      j = cyc + 1;
      applyStimulus(0, 8'hFF, 1'b0, 1'b0);
      fallQ0.push_back('{j + 4, 4'h5, 8'h00});
      riseQ0.push_back('{j + 8, 4'h9, 8'hFF});
      waitCycles(10);
      j = cyc + 1;
      applyStimulus(0, 8'h00, 1'b0, 1'b0);
      fallQ0.push_back('{j + 4, 4'h9, 8'h00});
      riseQ0.push_back('{j + 8, 4'h6, 8'h00});
      waitCycles(10);

      // Deselect part-way through ACCESS: back to IDLE, oe never rises.
      j = cyc + 1;
      applyStimulus(0, 8'h00, 1'b1, 1'b1);
      fallQ0.push_back('{j + 4, 4'h6, 8'h00});
      waitCycles(6);
      k = cyc + 1;
      applyStimulus(0, 8'h3A, 1'b0, 1'b0);
      waitCycles(3);
      applyStimulus(0, 8'h3A, 1'b1, 1'b1);
      waitCycles(6);
      checkOutput("abort_oe", oe0, 0);

      // Address toggling every two clocks keeps restarting ACCESS.
      k = cyc + 1;
      applyStimulus(0, 8'h10, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(0, 8'h20, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(0, 8'h10, 1'b0, 1'b0);
      waitCycles(2);
      applyStimulus(0, 8'h20, 1'b0, 1'b0);
      riseQ0.push_back('{k + 12, 4'hE, 8'h20});
      waitCycles(10);

      // Reset while in VALID, then a full access with ce still low.
      rst = 1'b1;
      waitCycles(1);
      checkOutput("rstvalid_oe", oe0, 0);
      checkOutput("rstvalid_data", data0, 0);
      checkOutput("rstvalid_romaddr", romAddr0, 0);
      rst = 1'b0;
      k = cyc + 1;
      riseQ0.push_back('{k + 6, 4'hE, 8'h20});
      waitCycles(8);

      // Reset while in HOLD after an address change.
      applyStimulus(0, 8'h3A, 1'b0, 1'b0);
      waitCycles(3);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("rsthold_oe", oe0, 0);
      checkOutput("rsthold_data", data0, 0);
      checkOutput("rsthold_romaddr", romAddr0, 0);
      rst = 1'b0;
      k = cyc + 1;
      riseQ0.push_back('{k + 6, 4'hC, 8'h3A});
      waitCycles(8);
      j = cyc + 1;
      applyStimulus(0, 8'h3A, 1'b1, 1'b1);
      fallQ0.push_back('{j + 4, 4'hC, 8'h00});
      waitCycles(6);

      // Corner instance: one access cycle, no hold.
      k = cyc + 1;
      applyStimulus(1, 8'h3A, 1'b0, 1'b0);
      riseQ1.push_back('{k + 3, 4'hC, 8'h3A});
      waitCycles(5);
      j = cyc + 1;
      applyStimulus(1, 8'h3B, 1'b0, 1'b0);
      fallQ1.push_back('{j + 2, 4'hC, 8'h00});
      riseQ1.push_back('{j + 3, 4'h5, 8'h3B});
      waitCycles(5);
      j = cyc + 1;
      applyStimulus(1, 8'h3B, 1'b1, 1'b1);
      fallQ1.push_back('{j + 2, 4'h5, 8'h00});
      waitCycles(5);

      waitCycles(4);
      checkOutput("riseQ0_pending", riseQ0.size(), 0);
      checkOutput("fallQ0_pending", fallQ0.size(), 0);
      checkOutput("riseQ1_pending", riseQ1.size(), 0);
      checkOutput("fallQ1_pending", fallQ1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
